// File: rtl/mem_port_arbiter.sv
// Arbitrates a single req/ack memory between the fetch port and the data port.
// Each access is latched, held until ack or timeout, and finishes with a one-cycle done pulse.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_done_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              err_o
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        D_WAIT,
        I_WAIT,
        D_DONE,
        I_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              last_d;
    logic              grant_d;
    logic              grant_i;
    logic              in_wait;
    logic              timeout_hit;
    logic              finish;
    logic [TW-1:0]     timer;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] if_cap;
    logic [DATA_W-1:0] d_cap;
    logic              err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Round-robin: on a tie the port that did not win last time gets the memory.
    always_comb begin
        grant_d     = 1'b0;
        grant_i     = 1'b0;
        in_wait     = (state == D_WAIT) || (state == I_WAIT);
        timeout_hit = in_wait && !mem_ack_i && (timer == T_LAST);
        finish      = in_wait && (mem_ack_i || timeout_hit);
        state_nx    = state;
        if (state == IDLE) begin
            grant_d = d_req_i && (!if_req_i || !last_d);
            grant_i = if_req_i && !grant_d;
        end
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nx = D_WAIT;
                end else if (grant_i) begin
                    state_nx = I_WAIT;
                end
            end
            D_WAIT: begin
                if (finish) begin
                    state_nx = D_DONE;
                end
            end
            I_WAIT: begin
                if (finish) begin
                    state_nx = I_DONE;
                end
            end
            D_DONE:  state_nx = IDLE;
            I_DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_d    <= 1'b0;
            timer     <= '0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            if_cap    <= '0;
            d_cap     <= '0;
            err       <= 1'b0;
        end else begin
            if (grant_d || grant_i) begin
                last_d   <= grant_d;
                timer    <= '0;
                lat_addr <= grant_d ? d_addr_i : if_addr_i;
                lat_we   <= grant_d && d_we_i;
                if (grant_d) begin
                    lat_wdata <= d_wdata_i;
                end
            end else if (in_wait && (timer != '1)) begin
                timer <= timer + 1'b1;
            end
            // A timed-out access returns zero data to the requesting port.
            if (finish) begin
                if (state == D_WAIT) begin
                    d_cap <= mem_ack_i ? mem_rdata_i : '0;
                end else begin
                    if_cap <= mem_ack_i ? mem_rdata_i : '0;
                end
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end

    assign mem_req_o   = in_wait;
    assign mem_we_o    = (state == D_WAIT) && lat_we;
    assign mem_addr_o  = lat_addr;
    assign mem_wdata_o = lat_wdata;
    assign if_done_o   = (state == I_DONE);
    assign d_done_o    = (state == D_DONE);
    assign if_rdata_o  = if_cap;
    assign d_rdata_o   = d_cap;
    assign err_o       = err;
    assign stall_o     = (if_req_i && !if_done_o) || (d_req_i && !d_done_o);

endmodule
